// File: rtl/data_mem_loader.sv
// Byte-stream to memory word loader: assembles little-endian words and drives the data memory write port.
// Optional running checksum of written words when DATA_MEM_LOADER_CHECKSUM_EN is defined.
module data_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  we,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(BYTES - 1);
  localparam logic [IDXW-1:0]       IDX_ONE  = IDXW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     rem_q;
  logic [IDXW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0]   asm_q, word_d;
  logic [ADDR_WIDTH-1:0]   addr_w_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    in_ready_q, we_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    word_d  = asm_q;
    word_d[{idx_q, 3'b000} +: 8] = in_data;
    case (state_q)
      S_IDLE:  if (start) state_d = (word_count == '0) ? S_DONE : S_RECV;
      S_RECV:  if (in_valid && idx_q == LAST_IDX) state_d = S_WRITE;
      S_WRITE: state_d = (rem_q == REM_ONE) ? S_DONE : S_RECV;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      addr_w_q   <= '0;
      data_out_q <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_RECV);
      we_q       <= (state_d == S_WRITE);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q <= start_addr;
            rem_q  <= word_count;
            idx_q  <= '0;
            asm_q  <= '0;
          end
        end
        S_RECV: begin
          if (in_valid) begin
            asm_q <= word_d;
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              addr_w_q   <= addr_q;
              data_out_q <= word_d;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
        end
        S_WRITE: begin
          addr_q <= addr_q + ADDR_ONE;
          rem_q  <= rem_q - REM_ONE;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign addr_w   = addr_w_q;
  assign data_out = data_out_q;

`ifdef DATA_MEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q;

  // Summed during the write cycle, so the total is settled by the time done pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cksum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      cksum_q <= '0;
    end else if (state_q == S_WRITE) begin
      cksum_q <= cksum_q + data_out_q;
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_data_mem_loader.sv
// Randomized self-checking bench for data_mem_loader against a queue-based write model.
module tb_data_mem_loader;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, we, busy, done;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] data_out, checksum;

  data_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .start_addr(start_addr),
    .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .addr_w(addr_w), .data_out(data_out), .we(we),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           exp_q[$];
  logic [7:0]    bq[$];
  logic [DW-1:0] exp_ck = '0;
  logic [DW-1:0] last_ck = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-port monitor: every we pulse must match the next expected write in order.
  always @(negedge clk) begin
    if (resetn && we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'(we), 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(addr_w), 64'(e.a));
        check("wr_data", 64'(data_out), 64'(e.d));
      end
      check("ready_during_we", 64'(in_ready), 64'd0);
    end
    if (resetn && done) begin
      check("done_cksum", 64'(checksum), 64'(exp_ck));
      check("busy_with_done", 64'(busy), 64'd1);
    end
  end

  task automatic check_reset_vals();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_addr_w",   64'(addr_w),   64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_we",       64'(we),       64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
  endtask

  // Builds the expected writes from bq, then drives a full load with optional idle gaps.
  task automatic load(input logic [AW-1:0] a, input int cnt, input int gap, input bit rnd_gap,
                      input bit mid_start);
    logic [DW-1:0] w;
    exp_ck = '0;
    for (int i = 0; i < cnt; i++) begin
      w = '0;
      for (int k = 0; k < DW / 8; k++) w = w | (DW'(bq[i * 4 + k]) << (8 * k));
      exp_q.push_back('{a: AW'((int'(a) + i) % (1 << AW)), d: w});
      if (CK_EN) exp_ck = exp_ck + w;
    end
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; word_count = (AW + 1)'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    if (cnt == 0) begin
      check("done_zero", 64'(done), 64'd1);
      check("ready_zero", 64'(in_ready), 64'd0);
    end else begin
      for (int i = 0; i < cnt; i++) begin
        for (int k = 0; k < DW / 8; k++) begin
          int g;
          g = rnd_gap ? int'($urandom_range(0, gap)) : gap;
          repeat (g) begin
            in_valid = 1'b0;
            start = mid_start; start_addr = a + 4'd7; word_count = 5'd3;
            check("ready_gap", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            start = 1'b0;
          end
          check("ready_byte", 64'(in_ready), 64'd1);
          in_valid = 1'b1; in_data = bq[i * 4 + k];
          @(posedge clk); #1;
        end
        in_valid = 1'b0; in_data = 8'($urandom);
        check("we_after_word", 64'(we), 64'd1);
        @(posedge clk); #1;
      end
      check("done_pulse", 64'(done), 64'd1);
      last_ck = checksum;
    end
    @(posedge clk); #1;
    check("busy_fall", 64'(busy), 64'd0);
    check("done_low", 64'(done), 64'd0);
    check("writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_s1_bytes();
    bq.delete();
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  endtask

  initial begin
    #2;
    check_reset_vals();
    #10 resetn = 1'b1;

    set_s1_bytes();
    load(4'd3, 2, 0, 1'b0, 1'b0);
    check("s1_hold_data", 64'(data_out), 64'h88776655);
    check("s1_hold_addr", 64'(addr_w), 64'd4);
    check("s1_cksum", 64'(last_ck), CK_EN ? 64'hCCAA8866 : 64'd0);

    bq.delete();
    load(4'd9, 0, 0, 1'b0, 1'b0);
    check("zero_no_we_data", 64'(data_out), 64'h88776655);

    set_s1_bytes();
    load(4'd15, 2, 0, 1'b0, 1'b0);
    check("wrap_addr", 64'(addr_w), 64'd0);

    set_s1_bytes();
    load(4'd3, 2, 3, 1'b0, 1'b1);
    check("gap_hold_data", 64'(data_out), 64'h88776655);
    check("gap_hold_addr", 64'(addr_w), 64'd4);

    @(posedge clk); #1;
    start = 1'b1; start_addr = 4'd5; word_count = 5'd2;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    @(posedge clk); #1;
    in_data = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    bq.delete();
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(4'd0, 1, 0, 1'b0, 1'b0);
    check("rst_then_data", 64'(data_out), 64'hDDCCBBAA);
    check("rst_then_addr", 64'(addr_w), 64'd0);

    for (int t = 0; t < 20; t++) begin
      int cnt;
      cnt = int'($urandom_range(0, 4));
      bq.delete();
      for (int b = 0; b < cnt * 4; b++) bq.push_back(8'($urandom));
      load(AW'($urandom_range(0, 15)), cnt, int'($urandom_range(0, 2)), 1'b1, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
